// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} pstate_t;

    localparam int OCC_W = 2;

    // RTYPE/SLL $0,$0,0 encodes as all zeros, which is the machine NOP.
    localparam logic [63:0] NOP_WORD = 64'h0;

    function automatic logic [OCC_W-1:0] occ_of(input pstate_t s);
        case (s)
            FULL:    return OCC_W'(1);
            SKID:    return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One holding register (payload + halt bit) with synchronous load/clear.
module pipe_skid_entry #(
    parameter int           W   = 65,
    parameter logic [W-1:0] CLR = '0
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear)     q_d = CLR;
        else if (load) q_d = d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) q_q <= CLR;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage with optional 2-entry skid, flush and sticky halt.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(NOP_WORD),
    parameter bit                SKID_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int            EW      = DATA_W + 1;
    localparam logic [EW-1:0] ENT_CLR = {1'b0, BUBBLE};

    pstate_t       state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [EW-1:0] main_q, skid_q, main_din;
    logic          main_load, main_clear, skid_load, skid_clear;
    logic          halted, act, in_fire, out_fire;

    // A halt word parked in main freezes the stage, so it stays sticky until reset.
    assign halted    = (state_q != EMPTY) & main_q[DATA_W];
    assign act       = en & ~halted;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q[DATA_W-1:0];
    assign out_halt  = halted;
    assign occupancy = occ_of(state_q);
    assign in_ready  = SKID_EN ? in_ready_q : ((~out_valid | out_ready) & ~halted);
    assign in_fire   = act & in_valid & in_ready;
    assign out_fire  = act & out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_din   = {in_halt, in_data};
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (act && flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                SKID: if (out_fire) begin
                    state_d    = FULL;
                    main_din   = skid_q;
                    main_load  = 1'b1;
                    skid_clear = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != SKID) & ~halted & ~(main_load & main_din[DATA_W]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_entry #(.W(EW), .CLR(ENT_CLR)) u_main (
        .CLK(CLK), .nRST(nRST), .load(main_load), .clear(main_clear),
        .d(main_din), .q(main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_skid_entry #(.W(EW), .CLR(ENT_CLR)) u_skid (
                .CLK(CLK), .nRST(nRST), .load(skid_load), .clear(skid_clear),
                .d({in_halt, in_data}), .q(skid_q)
            );
        end else begin : g_noskid
            assign skid_q = ENT_CLR;
        end
    endgenerate

    a_no_fire_in_skid: assert property (@(posedge CLK) disable iff (!nRST)
        !(in_fire && state_q == SKID));

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (act) begin
            if (out_valid && !out_ready) stall_cnt_d  = stall_cnt_q + 32'd1;
            if (!out_valid)              bubble_cnt_d = bubble_cnt_q + 32'd1;
            if (flush)                   flush_cnt_d  = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (SKID_EN=1, non-zero BUBBLE to expose clear paths).
module tb_pipe_stage_buf;

    localparam int          DW  = 64;
    localparam logic [63:0] BUB = 64'h0000_0000_DEAD_0000;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          en = 1'b0, flush = 1'b0, in_valid = 1'b0, in_halt = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_halt;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_chk = 0;
    int n_fail = 0;

    pipe_stage_buf #(.DATA_W(DW), .BUBBLE(BUB), .SKID_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_halt(out_halt), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_halt = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle();
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL rst_data got %h exp %h", out_data, BUB); end
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
        n_chk++; if (out_halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt got %b exp 0", out_halt); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_full_throughput();
        idle();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'(i);
            tick();
            n_chk++; if (out_data !== 64'(i)) begin n_fail++; $display("FAIL tp_data[%0d] got %h exp %h", i, out_data, 64'(i)); end
            n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL tp_occ[%0d] got %0d exp 1", i, occupancy); end
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL tp_in_ready[%0d] got %b exp 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL tp_drain_occ got %0d exp 0", occupancy); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL tp_drain_data got %h exp %h", out_data, BUB); end
    endtask

    task automatic test_skid();
        idle();
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_occ1 got %0d exp 1", occupancy); end
        in_data = 64'h22;
        tick();
        n_chk++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ2 got %0d exp 2", occupancy); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready got %b exp 0", in_ready); end
        n_chk++; if (out_data !== 64'h11) begin n_fail++; $display("FAIL skid_head got %h exp 11", out_data); end
        // an extra offer while full must not be captured
        in_data = 64'h99;
        tick();
        n_chk++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_hold_occ got %0d exp 2", occupancy); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (out_data !== 64'h22) begin n_fail++; $display("FAIL skid_second got %h exp 22", out_data); end
        n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_occ_after got %0d exp 1", occupancy); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_after got %b exp 1", in_ready); end
        tick();
        n_chk++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty got occ %0d valid %b exp 0 0", occupancy, out_valid); end
    endtask

    task automatic test_en_gating();
        idle();
        in_valid = 1'b1; in_data = 64'h77;
        tick();
        en = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 64'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL en_occ[%0d] got %0d exp 1", i, occupancy); end
            n_chk++; if (out_data !== 64'h77) begin n_fail++; $display("FAIL en_data[%0d] got %h exp 77", i, out_data); end
        end
        idle();
        out_ready = 1'b1;
        tick();
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL en_drain_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1'b1; in_data = 64'h33;
        tick();
        in_data = 64'h44;
        tick();
        flush = 1'b1; in_data = 64'h55;
        tick();
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL fl2_occ got %0d exp 0", occupancy); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL fl2_data got %h exp %h", out_data, BUB); end
        // occupancy 1 with in_ready high: flush must still discard the capture
        flush = 1'b0; in_data = 64'h33;
        tick();
        flush = 1'b1; in_data = 64'h55;
        tick();
        n_chk++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fl1_occ got occ %0d valid %b exp 0 0", occupancy, out_valid); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL fl1_data got %h exp %h", out_data, BUB); end
        idle();
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_ghost got valid %b data %h exp 0", out_valid, out_data); end
    endtask

    task automatic test_reset_mid();
        idle();
        in_valid = 1'b1; in_data = 64'hA5;
        tick();
        in_valid = 1'b0;
        n_chk++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL rm_pre_occ got %0d exp 1", occupancy); end
        #2 nRST = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", out_valid); end
        n_chk++; if (out_data !== BUB) begin n_fail++; $display("FAIL rm_data got %h exp %h", out_data, BUB); end
        n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rm_occ got %0d exp 0", occupancy); end
        #1 nRST = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        idle();
        in_valid = 1'b1; in_halt = 1'b1; in_data = 64'h66;
        tick();
        n_chk++; if (out_halt !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b exp 1", out_halt); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready got %b exp 0", in_ready); end
        in_halt = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 64'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (out_data !== 64'h66 || out_valid !== 1'b1) begin n_fail++; $display("FAIL halt_hold[%0d] got %h/%b exp 66/1", i, out_data, out_valid); end
            n_chk++; if (out_halt !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_sticky[%0d] got halt %b ready %b exp 1 0", i, out_halt, in_ready); end
        end
        do_reset();
        n_chk++; if (out_halt !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_clr got halt %b valid %b exp 0 0", out_halt, out_valid); end
    endtask

    task automatic test_halt_in_skid();
        idle();
        in_valid = 1'b1; in_data = 64'h10;
        tick();
        in_halt = 1'b1; in_data = 64'h20;
        tick();
        n_chk++; if (out_halt !== 1'b0 || occupancy !== 2'd2) begin n_fail++; $display("FAIL hs_pre got halt %b occ %0d exp 0 2", out_halt, occupancy); end
        in_valid = 1'b0; in_halt = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (out_halt !== 1'b1 || out_data !== 64'h20) begin n_fail++; $display("FAIL hs_promote got halt %b data %h exp 1 20", out_halt, out_data); end
        tick();
        n_chk++; if (out_valid !== 1'b1 || out_data !== 64'h20) begin n_fail++; $display("FAIL hs_hold got valid %b data %h exp 1 20", out_valid, out_data); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_full_throughput();
        test_skid();
        test_en_gating();
        test_flush();
        test_reset_mid();
        test_halt();
        test_halt_in_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage latches (e.g. EX/MEM); one generic pipeline stage register for any boundary.
- Carries an opaque payload of DATA_W bits, a valid bit and a halt bit.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops a word.
- Keeps the existing flush-to-bubble and sticky-halt semantics.

Parameters:
- DATA_W, 64: payload width in bits.
- BUBBLE, '0 (DATA_W bits): payload driven/held when the stage is empty or flushed (the NOP encoding, e.g. RTYPE/SLL).
- SKID_EN, 1: 1 = 2-entry skid buffer (full throughput under back-pressure); 0 = single register, in_ready combinationally follows out_ready.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  global advance qualifier (iHit|dHit); when 0 the stage holds all state.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  upstream word is a HALT.
- out_valid  out  1  head word present.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  DATA_W  head payload (BUBBLE when !out_valid).
- out_halt  out  1  sticky halt indicator.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (async, nRST=0): state EMPTY, out_valid=0, out_data=BUBBLE, out_halt=0, occupancy=0, skid entry cleared.
- Transfers:
  - in_fire = en & in_valid & in_ready.
  - out_fire = en & out_valid & out_ready.
  - Both evaluate in the same cycle; state updates on the rising CLK edge.
- in_ready:
  - SKID_EN=1: registered, = (state != SKID) & !halted.
  - SKID_EN=0: = (!out_valid | out_ready) & !halted.
- States (SKID_EN=1):
  - EMPTY: in_fire -> FULL, word loaded to main, latency 1 cycle.
  - FULL:
    - in_fire & out_fire -> FULL, main replaced.
    - in_fire only -> SKID, word goes to skid.
    - out_fire only -> EMPTY.
  - SKID: out_fire -> FULL, skid moves to main. in_ready=0, so no capture.
- Ordering: strict FIFO; the skid word never overtakes main.
- en=0: no transfer and no state change, even with in_valid/out_ready high. flush is also ignored while en=0, matching the existing latches.
- Flush (en=1, flush=1, not halted):
  - Next state EMPTY, both entries cleared, out_data=BUBBLE.
  - A simultaneous in_fire is discarded.
  - Flush has priority over capture.
- Halt:
  - When a word with in_halt=1 reaches main, halted is set and out_halt=1 from the next edge.
  - While halted: in_ready=0, out_valid=1, out_data frozen, flush ignored, en ignored.
  - Only nRST clears it. Halt has priority over flush.
  - A halt word sitting in skid becomes sticky only once promoted to main.
- occupancy = number of valid entries; never exceeds 2.
  - Overflow is impossible by construction.
  - Assertion: no in_fire in SKID.
- Reset mid-operation: all entries dropped immediately, including halted state; no partial output.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds three outputs and counters, all reset to 0:
  - stall_cnt[31:0]: cycles with out_valid & !out_ready & en.
  - bubble_cnt[31:0]: cycles with !out_valid & en.
  - flush_cnt[15:0]: accepted flushes.
- Counters wrap modulo 2^N and freeze while halted.
- When undefined: no ports, no logic, identical functional behaviour.

Decomposition:
- Shared package pipe_pkg: typedef pstate_t {EMPTY, FULL, SKID}; occupancy width constant; default BUBBLE constant derived from cpu_types_pkg (RTYPE/SLL encoding).
- One natural sub-module: pipe_skid_entry, a single DATA_W+1-bit holding register with load/clear.
  - Instantiated twice for SKID_EN=1, once for SKID_EN=0.
- Per-stage field packing stays in each stage's interface, outside this block.

Test Plan:
- Reset mid-stream:
  - Stimulus: load data=0xA5 (occupancy 1), then assert nRST=0 asynchronously between edges.
  - Response: out_valid=0, out_data=BUBBLE, occupancy=0 immediately.
- Back-pressure skid, SKID_EN=1:
  - Stimulus: out_ready=0, push 0x11 then 0x22.
  - Response: occupancy=2, in_ready=0.
  - Then raise out_ready: outputs 0x11 then 0x22 on consecutive cycles, no loss or duplication.
- Full throughput:
  - Stimulus: en=1, in_valid=out_ready=1 for 8 cycles, data 0..7.
  - Response: out_data 0..7 with 1-cycle latency, occupancy stays 1.
- en gating:
  - Stimulus: en=0 for 3 cycles with in_valid=out_ready=flush=1.
  - Response: state, occupancy and out_data unchanged.
- Flush vs capture:
  - Stimulus: occupancy=2 (0x33, 0x44), then flush=1 with in_valid=1, data 0x55.
  - Response: next cycle occupancy=0, out_data=BUBBLE; 0x55 never appears.
- Sticky halt:
  - Stimulus: push 0x66 with in_halt=1, then flush=1 and in_valid=1.
  - Response: out_halt=1, out_data=0x66 held, in_ready=0 indefinitely; clears only on nRST.
